// File: rtl/sync_ram_if.sv
// ---------------------------------------------------------------------------
// sync_ram_if
//   Request/response bundle between a core-side request master and sync_ram.
//
//   Parameters
//     WIDTH  bits per word
//     DEPTH  number of words (address width is derived from it)
//
//   Signals (direction as seen by the RAM, i.e. the slave modport)
//     req_valid  in   request present
//     req_ready  out  RAM accepts a request this cycle
//     req_rw     in   1 = write, 0 = read
//     req_addr   in   binary word address
//     req_data   in   write data
//     clear      in   start a clear sequence (only honoured while idle)
//     busy       out  clear sequence in progress
//     rsp_valid  out  one-cycle pulse per accepted read
//     rsp_data   out  read data, held until the next accepted read
// ---------------------------------------------------------------------------
interface sync_ram_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             req_valid;
  logic             req_ready;
  logic             req_rw;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_data;
  logic             clear;
  logic             busy;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_rw, req_addr, req_data, clear,
    input  req_ready, busy, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_data, clear,
    output req_ready, busy, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sync_ram.sv
// ---------------------------------------------------------------------------
// sync_ram
//   Parametrised single-port synchronous RAM with a valid/ready request
//   handshake, a registered read path and a clear sequencer that zeroes every
//   word after reset or on command.
//
//   Parameters
//     WIDTH  bits per word (>= 1)
//     DEPTH  number of words (>= 2); AW = $clog2(DEPTH) is derived
//
//   Ports
//     clk    in   single clock, rising-edge
//     rst_n  in   asynchronous active-low reset
//     bus    sync_ram_if.slave request/response bundle (see sync_ram_if)
// ---------------------------------------------------------------------------
module sync_ram #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  sync_ram_if.slave  bus
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t           state, state_nx;
  logic [AW-1:0]    ptr, ptr_nx;
  logic             ready;
  logic             accept;
  logic             wr_en;
  logic             rd_en;
  logic             in_range;
  logic [WIDTH-1:0] rd_word;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;

  logic [WIDTH-1:0] mem [DEPTH];

  // -------------------------------------------------------------------------
  // Handshake decode. Ready depends on the state register only, never on
  // req_valid, so a master may use it to decide whether to present a request.
  // -------------------------------------------------------------------------
  assign ready  = (state == ST_IDLE);
  assign accept = bus.req_valid & ready;

  // Out-of-range addresses exist only when DEPTH is not a power of two.
  generate
    if ((1 << AW) == DEPTH) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_partial_range
      assign in_range = (bus.req_addr < LAST_ADDR) || (bus.req_addr == LAST_ADDR);
    end
  endgenerate

  assign wr_en   = accept &  bus.req_rw & in_range;
  assign rd_en   = accept & ~bus.req_rw;
  assign rd_word = in_range ? mem[bus.req_addr] : '0;

  // -------------------------------------------------------------------------
  // Clear sequencer: state register.
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  // Clear sequencer: next state. CLEAR walks ptr from 0 to DEPTH-1, one word
  // per cycle; a clear request arriving during CLEAR is ignored.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_nx = state;
    ptr_nx   = ptr;
    case (state)
      ST_CLEAR: begin
        if (ptr == LAST_ADDR) begin
          state_nx = ST_IDLE;
          ptr_nx   = '0;
        end else begin
          ptr_nx = ptr + 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.clear) begin
          state_nx = ST_CLEAR;
          ptr_nx   = '0;
        end
      end
      default: begin
        state_nx = ST_CLEAR;
        ptr_nx   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Storage. A request accepted together with clear executes on that edge;
  // the zeroing writes start on the following edge.
  // -------------------------------------------------------------------------
  // NOTE: the array has no reset; the clear sequence that follows every reset
  // establishes its contents, which keeps it mappable to RAM macros.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_en) begin
      mem[bus.req_addr] <= bus.req_data;
    end
  end

  // -------------------------------------------------------------------------
  // Registered read path. rsp_data only moves on an accepted read (or reset);
  // writes, clears and idle cycles leave it holding the last response.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rd_en;
      if (rd_en) begin
        rsp_data_q <= rd_word;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.busy      = (state == ST_CLEAR);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sync_ram.sv
// ---------------------------------------------------------------------------
// tb_sync_ram
//   Directed bench for sync_ram: a 4x4 instance (main behaviour) and an 8x6
//   instance (non-power-of-two depth). Inputs change and outputs are sampled
//   1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_sync_ram;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sync_ram_if #(.WIDTH(4), .DEPTH(4)) ba ();
  sync_ram_if #(.WIDTH(8), .DEPTH(6)) bb ();

  sync_ram #(.WIDTH(4), .DEPTH(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ba.slave)
  );

  sync_ram #(.WIDTH(8), .DEPTH(6)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bb.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ba.req_valid = 1'b0;
    ba.req_rw    = 1'b0;
    ba.req_addr  = '0;
    ba.req_data  = '0;
    ba.clear     = 1'b0;
  endtask

  task automatic idle_b();
    bb.req_valid = 1'b0;
    bb.req_rw    = 1'b0;
    bb.req_addr  = '0;
    bb.req_data  = '0;
    bb.clear     = 1'b0;
  endtask

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle_a();
    idle_b();
    cyc();
    cyc();

    // ---- reset state ----
    check_bit("rst_ready", ba.req_ready, 1'b0);
    check_bit("rst_busy", ba.busy, 1'b1);
    check_bit("rst_rsp_valid", ba.rsp_valid, 1'b0);
    check4("rst_rsp_data", ba.rsp_data, 4'h0);
    check_bit("rst_b_busy", bb.busy, 1'b1);

    // ---- initial clear: 4 cycles on A, 6 cycles on B ----
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (i <= 4) begin
        check_bit("init_clr_busy", ba.busy, (i < 4));
        check_bit("init_clr_ready", ba.req_ready, (i == 4));
      end
      check_bit("b_init_clr_busy", bb.busy, (i < 6));
    end

    // ---- back-to-back reads of the cleared array ----
    ba.req_valid = 1'b1;
    ba.req_rw    = 1'b0;
    for (int a = 0; a < 4; a++) begin
      ba.req_addr = 2'(a);
      cyc();
      check_bit("zero_rd_valid", ba.rsp_valid, 1'b1);
      check4("zero_rd_data", ba.rsp_data, 4'h0);
    end
    idle_a();
    cyc();
    check_bit("zero_rd_end", ba.rsp_valid, 1'b0);

    // ---- write 0xA to addr 1, read it on the next cycle ----
    ba.req_valid = 1'b1;
    ba.req_rw    = 1'b1;
    ba.req_addr  = 2'd1;
    ba.req_data  = 4'hA;
    cyc();
    check_bit("wr_no_rsp", ba.rsp_valid, 1'b0);
    check4("wr_keeps_data", ba.rsp_data, 4'h0);
    ba.req_rw = 1'b0;
    cyc();
    check_bit("raw_valid", ba.rsp_valid, 1'b1);
    check4("raw_data", ba.rsp_data, 4'hA);
    idle_a();
    cyc();
    check_bit("raw_valid_drop", ba.rsp_valid, 1'b0);
    check4("raw_hold1", ba.rsp_data, 4'hA);
    cyc();
    check4("raw_hold2", ba.rsp_data, 4'hA);

    // ---- fill addr i <= i+5, then 4 back-to-back reads ----
    ba.req_valid = 1'b1;
    ba.req_rw    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ba.req_addr = 2'(i);
      ba.req_data = 4'(i + 5);
      cyc();
    end
    ba.req_rw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ba.req_addr = 2'(i);
      cyc();
      check_bit("b2b_valid", ba.rsp_valid, 1'b1);
      check4("b2b_data", ba.rsp_data, 4'(i + 5));
    end
    idle_a();
    cyc();
    check_bit("b2b_end_valid", ba.rsp_valid, 1'b0);
    check4("b2b_end_hold", ba.rsp_data, 4'h8);

    // ---- clear together with a read of addr 2 (holds 7) ----
    ba.clear     = 1'b1;
    ba.req_valid = 1'b1;
    ba.req_rw    = 1'b0;
    ba.req_addr  = 2'd2;
    cyc();
    check_bit("clr_rd_valid", ba.rsp_valid, 1'b1);
    check4("clr_rd_data", ba.rsp_data, 4'h7);
    check_bit("clr_busy0", ba.busy, 1'b1);
    check_bit("clr_ready0", ba.req_ready, 1'b0);
    // A write of 0xF to addr 0 and a repeated clear are presented throughout
    // the sequence; neither may take effect.
    ba.req_rw   = 1'b1;
    ba.req_addr = 2'd0;
    ba.req_data = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check_bit("clr_busy", ba.busy, (k < 4));
      check_bit("clr_ready", ba.req_ready, (k == 4));
      check_bit("clr_no_rsp", ba.rsp_valid, 1'b0);
      check4("clr_hold", ba.rsp_data, 4'h7);
    end
    idle_a();
    ba.req_valid = 1'b1;
    for (int a = 0; a < 4; a++) begin
      ba.req_addr = 2'(a);
      cyc();
      check_bit("post_clr_valid", ba.rsp_valid, 1'b1);
      check4("post_clr_data", ba.rsp_data, 4'h0);
    end
    idle_a();

    // ---- reset asserted mid-clear at ptr = 2 ----
    ba.req_valid = 1'b1;
    ba.req_rw    = 1'b1;
    ba.req_addr  = 2'd1;
    ba.req_data  = 4'h9;
    cyc();
    ba.req_rw = 1'b0;
    ba.clear  = 1'b1;
    cyc();
    check4("pre_rst_rd", ba.rsp_data, 4'h9);
    check_bit("pre_rst_busy", ba.busy, 1'b1);
    idle_a();
    cyc();
    cyc();
    check4("mid_clr_hold", ba.rsp_data, 4'h9);
    rst_n = 1'b0;
    #1;
    check_bit("async_rst_valid", ba.rsp_valid, 1'b0);
    check_bit("async_rst_ready", ba.req_ready, 1'b0);
    check_bit("async_rst_busy", ba.busy, 1'b1);
    check4("async_rst_data", ba.rsp_data, 4'h0);
    cyc();
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check_bit("rerun_clr_busy", ba.busy, (i < 4));
      check_bit("rerun_clr_ready", ba.req_ready, (i == 4));
    end
    ba.req_valid = 1'b1;
    ba.req_addr  = 2'd1;
    cyc();
    check_bit("rerun_rd_valid", ba.rsp_valid, 1'b1);
    check4("rerun_rd_data", ba.rsp_data, 4'h0);
    idle_a();
    cyc();
    cyc();

    // ---- 8x6 instance: out-of-range addresses ----
    check_bit("b_idle_busy", bb.busy, 1'b0);
    check_bit("b_idle_ready", bb.req_ready, 1'b1);
    bb.req_valid = 1'b1;
    bb.req_rw    = 1'b1;
    bb.req_addr  = 3'd5;
    bb.req_data  = 8'h3C;
    cyc();
    bb.req_addr = 3'd7;
    bb.req_data = 8'hFF;
    cyc();
    check_bit("b_wr_no_rsp", bb.rsp_valid, 1'b0);
    bb.req_rw   = 1'b0;
    bb.req_addr = 3'd5;
    cyc();
    check_bit("b_rd5_valid", bb.rsp_valid, 1'b1);
    check8("b_rd5_data", bb.rsp_data, 8'h3C);
    bb.req_addr = 3'd7;
    cyc();
    check_bit("b_rd7_valid", bb.rsp_valid, 1'b1);
    check8("b_rd7_data", bb.rsp_data, 8'h00);
    bb.req_addr = 3'd1;
    cyc();
    check8("b_rd1_data", bb.rsp_data, 8'h00);
    bb.req_addr = 3'd5;
    cyc();
    check8("b_rd5_again", bb.rsp_data, 8'h3C);
    bb.req_addr = 3'd6;
    cyc();
    check_bit("b_rd6_valid", bb.rsp_valid, 1'b1);
    check8("b_rd6_data", bb.rsp_data, 8'h00);
    idle_b();
    cyc();
    check_bit("b_end_valid", bb.rsp_valid, 1'b0);

    // ---- 8x6 clear on command lasts 6 cycles ----
    bb.clear = 1'b1;
    cyc();
    idle_b();
    check_bit("b_cmd_clr_busy0", bb.busy, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      check_bit("b_cmd_clr_busy", bb.busy, (i < 6));
    end
    bb.req_valid = 1'b1;
    bb.req_addr  = 3'd5;
    cyc();
    check8("b_cmd_clr_data", bb.rsp_data, 8'h00);
    idle_b();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
